// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported I/D memory between fetch and data stages, data-first with a fetch anti-starvation streak limit and an ack watchdog
module unified_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ready_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ready_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          err_o
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic mem_we_q, mem_we_d, err_q, err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rdata;
  logic idle, busy, fin, abort, gnt_i, gnt_d, at_max;
  always_comb begin
    idle = state_q == IDLE;
    busy = state_q == BUSY_I || state_q == BUSY_D;
    at_max = streak_q == SW'(MAX_STREAK);
    gnt_i = idle && if_req_i && (!dm_req_i || at_max);
    gnt_d = idle && dm_req_i && !gnt_i;
    abort = busy && !mem_ack_i && TIMEOUT != 0 && wdog_q == WW'(TIMEOUT - 1);
    fin = busy && (mem_ack_i || abort);
    rdata = mem_ack_i && !mem_we_q ? mem_rdata_i : '0;
    state_d = gnt_i ? BUSY_I : gnt_d ? BUSY_D : fin ? (state_q == BUSY_I ? DONE_I : DONE_D) : busy ? state_q : IDLE;
    mem_addr_d = gnt_i ? if_addr_i : gnt_d ? dm_addr_i : mem_addr_q;
    mem_wdata_d = gnt_d ? dm_wdata_i : mem_wdata_q;
    mem_we_d = gnt_d ? dm_we_i : gnt_i || fin ? 1'b0 : mem_we_q;
    wdog_d = gnt_i || gnt_d ? '0 : busy ? wdog_q + 1'b1 : wdog_q;
    err_d = err_q || abort;
    if_rdata_d = fin && state_q == BUSY_I ? rdata : if_rdata_q;
    dm_rdata_d = fin && state_q == BUSY_D ? rdata : dm_rdata_q;
    streak_d = !if_req_i || gnt_i ? '0 : gnt_d && !at_max ? streak_q + 1'b1 : streak_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      streak_q <= '0;
      wdog_q <= '0;
      mem_we_q <= 1'b0;
      err_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      streak_q <= streak_d;
      wdog_q <= wdog_d;
      mem_we_q <= mem_we_d;
      err_q <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign mem_req_o = busy;
  assign mem_we_o = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ready_o = state_q == DONE_I;
  assign dm_ready_o = state_q == DONE_D;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign if_stall_o = if_req_i && !if_ready_o;
  assign dm_stall_o = dm_req_i && !dm_ready_o;
  assign err_o = err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with directed and random requesters against a behavioural memory
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic ack_r = 0, spur_ack = 0, mem_ack;
  logic if_ready_o, if_stall_o, dm_ready_o, dm_stall_o, mem_req_o, mem_we_o, err_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  int checks = 0, errors = 0;
  bit hang = 0, prev_req = 0, dm_done = 0;
  int ack_max = 0, wcnt = 0, cyc, c1, c2;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] if_q[$], dm_q[$];
  bit glog[$];
  assign mem_ack = ack_r | spur_ack;
  always #5 clk = ~clk;
  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .err_o(err_o)
  );
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h8C01_0044;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction
  function automatic logic [6:0] order7();
    logic [6:0] o = '0;
    for (int i = 0; i < 7 && i < glog.size(); i++) o[6-i] = glog[i];
    return o;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_fetch(input logic [31:0] a, input bit keep, output int n);
    if_req = 1;
    if_addr = a;
    if_q.push_back(dflt(a));
    n = 1;
    do begin
      step(1);
      n++;
    end while (!if_ready_o && n < 500);
    chk("if_ready in time", if_ready_o, 1);
    if (!keep) if_req = 0;
  endtask
  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] d, input bit keep, input bit abort, output int n);
    dm_req = 1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    dm_q.push_back(we || abort ? 32'h0 : exp_rd(a));
    if (we && !abort) shadow[a] = d;
    n = 1;
    do begin
      step(1);
      n++;
    end while (!dm_ready_o && n < 500);
    chk("dm_ready in time", dm_ready_o, 1);
    if (!keep) dm_req = 0;
  endtask
  initial forever begin
    @(negedge clk);
    if (ack_r) ack_r = 0;
    else if (mem_req_o && !hang) begin
      if (wcnt == 0) begin
        ack_r = 1;
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else mem_rdata = mem.exists(mem_addr_o) ? mem[mem_addr_o] : dflt(mem_addr_o);
        wcnt = $urandom_range(0, ack_max);
      end else wcnt--;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("if_stall", if_stall_o, if_req & ~if_ready_o);
    chk("dm_stall", dm_stall_o, dm_req & ~dm_ready_o);
    if (if_ready_o) begin
      if (if_q.size() == 0) chk("unexpected if_ready", if_ready_o, 0);
      else chk("if_rdata", if_rdata_o, if_q.pop_front());
    end
    if (dm_ready_o) begin
      if (dm_q.size() == 0) chk("unexpected dm_ready", dm_ready_o, 0);
      else chk("dm_rdata", dm_rdata_o, dm_q.pop_front());
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_req_o && !prev_req) begin
      if (mem_addr_o[28]) begin
        glog.push_back(1);
        chk("grant D addr", mem_addr_o, dm_addr);
        chk("grant D we", mem_we_o, dm_we);
        if (dm_we) chk("grant D wdata", mem_wdata_o, dm_wdata);
      end else begin
        glog.push_back(0);
        chk("grant I addr", mem_addr_o, if_addr);
        chk("grant I we", mem_we_o, 0);
      end
    end
    prev_req = mem_req_o;
  end
  initial begin
    #500000;
    $display("FAIL global timeout: checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    step(2);
    chk("reset ctl", {mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o}, 0);
    chk("reset mem_addr", mem_addr_o, 0);
    chk("reset mem_wdata", mem_wdata_o, 0);
    chk("reset if_rdata", if_rdata_o, 0);
    chk("reset dm_rdata", dm_rdata_o, 0);
    rst = 0;
    step(1);
    do_fetch(32'h40, 0, cyc);
    chk("t1 latency", cyc, 3);
    chk("t1 if_rdata", if_rdata_o, 32'h8C01_0004);
    step(2);
    glog.delete();
    fork
      do_fetch(32'h80, 0, c1);
      do_data(0, 32'h1000_0100, 0, 0, 0, c2);
    join
    step(2);
    chk("t2 grant count", glog.size(), 2);
    chk("t2 first grant D", glog.size() > 1 ? {glog[0], glog[1]} : 2'b00, 2'b10);
    chk("t2 queues drained", if_q.size() + dm_q.size(), 0);
    glog.delete();
    dm_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) do_data(1, 32'h1000_0010 + 32'(4 * i), $urandom, i < 5, 0, c2);
        dm_done = 1;
      end
      begin
        for (int k = 0; !dm_done; k++) do_fetch(32'h200 + 32'(4 * k), 1, c1);
        if_req = 0;
      end
    join
    step(2);
    chk("t3 grant count", glog.size() >= 7, 1);
    chk("t3 grant order", order7(), 7'b1111011);
    chk("t4 err before", err_o, 0);
    hang = 1;
    do_data(0, 32'h1000_0300, 0, 0, 1, cyc);
    chk("t4 abort latency", cyc, 10);
    chk("t4 err set", err_o, 1);
    chk("t4 dm_rdata", dm_rdata_o, 0);
    hang = 0;
    step(2);
    do_fetch(32'h300, 0, cyc);
    chk("t4 fetch latency", cyc, 3);
    chk("t4 err sticky", err_o, 1);
    step(2);
    hang = 1;
    dm_req = 1;
    dm_we = 0;
    dm_addr = 32'h1000_0040;
    for (int i = 0; i < 20 && !mem_req_o; i++) step(1);
    chk("t5 granted", mem_req_o, 1);
    step(2);
    rst = 1;
    step(1);
    chk("t5 mem_req after rst", mem_req_o, 0);
    chk("t5 dm_ready after rst", dm_ready_o, 0);
    chk("t5 err after rst", err_o, 0);
    rst = 0;
    hang = 0;
    dm_q.push_back(exp_rd(32'h1000_0040));
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!dm_ready_o && cyc < 50);
    chk("t5 regrant ready", dm_ready_o, 1);
    dm_req = 0;
    step(2);
    spur_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t6 no mem_req", mem_req_o, 0);
      chk("t6 no ready", {if_ready_o, dm_ready_o}, 0);
    end
    spur_ack = 0;
    step(2);
    ack_max = 3;
    fork
      for (int i = 0; i < 30; i++) begin
        step($urandom_range(0, 3));
        do_fetch(32'($urandom_range(0, 1023)) << 2, 0, c1);
      end
      for (int j = 0; j < 30; j++) begin
        step($urandom_range(0, 3));
        do_data(1'($urandom_range(0, 1)), 32'h1000_0000 + (32'($urandom_range(0, 7)) << 2), $urandom, 0, 0, c2);
      end
    join
    step(5);
    chk("final queues drained", if_q.size() + dm_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
